// File: rtl/apb_arb_master_if.sv
// APB bus bundle between apb_arb_master and one APB slave.
// Ports: P_addr/P_selx/P_enable/P_write/P_wdata (master->slave),
//        P_ready/P_slverr/P_rdata (slave->master); master/slave modports.
interface apb_arb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] P_addr;
  logic              P_selx;
  logic              P_enable;
  logic              P_write;
  logic [DATA_W-1:0] P_wdata;
  logic              P_ready;
  logic              P_slverr;
  logic [DATA_W-1:0] P_rdata;

  modport master (
    output P_addr, P_selx, P_enable, P_write, P_wdata,
    input  P_ready, P_slverr, P_rdata
  );

  modport slave (
    input  P_addr, P_selx, P_enable, P_write, P_wdata,
    output P_ready, P_slverr, P_rdata
  );
endinterface

// File: rtl/apb_arb_master.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Latency: gnt 1 cycle after request seen in IDLE, done >= 3 cycles after request (zero-wait slave).
// Backpressure: slave stalls via P_ready=0, bounded by TIMEOUT ACCESS cycles; requests ignored while busy.
// Ports: P_clk/P_rst (sync active-low), rqN_* command in / gnt,done pulses out,
//        rsp_rdata/rsp_err result (held until next done), apb = APB master modport.
module apb_arb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              P_clk,
  input  logic              P_rst,
  input  logic              rq0_req,
  input  logic              rq0_write,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  output logic              rq0_gnt,
  output logic              rq0_done,
  input  logic              rq1_req,
  input  logic              rq1_write,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  output logic              rq1_gnt,
  output logic              rq1_done,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  apb_arb_master_if.master  apb
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Value of the wait counter during the last ACCESS cycle allowed before abort.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q;
  logic              prio1_q;   // 1: requester 1 wins a tie
  logic              owner_q;   // requester currently holding the bus
  logic [7:0]        wait_q;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic              selx_q;
  logic              enable_q;
  logic              gnt0_q, gnt1_q;
  logic              done0_q, done1_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  // Requester 1 wins when alone, or when both ask and it holds priority.
  logic pick1_d;
  assign pick1_d = rq1_req & (~rq0_req | prio1_q);

  always_ff @(posedge P_clk) begin
    if (!P_rst) begin
      state_q  <= IDLE;
      prio1_q  <= 1'b0;
      owner_q  <= 1'b0;
      wait_q   <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      selx_q   <= 1'b0;
      enable_q <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // gnt/done are single-cycle pulses unless re-asserted below.
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rq0_req || rq1_req) begin
            state_q  <= SETUP;
            selx_q   <= 1'b1;
            enable_q <= 1'b0;
            owner_q  <= pick1_d;
            gnt0_q   <= ~pick1_d;
            gnt1_q   <= pick1_d;
            prio1_q  <= ~pick1_d;
            addr_q   <= pick1_d ? rq1_addr  : rq0_addr;
            write_q  <= pick1_d ? rq1_write : rq0_write;
            wdata_q  <= pick1_d ? rq1_wdata : rq0_wdata;
            wait_q   <= '0;
          end
        end
        SETUP: begin
          state_q  <= ACCESS;
          enable_q <= 1'b1;
        end
        ACCESS: begin
          if (apb.P_ready) begin
            state_q  <= IDLE;
            selx_q   <= 1'b0;
            enable_q <= 1'b0;
            done0_q  <= ~owner_q;
            done1_q  <= owner_q;
            rdata_q  <= write_q ? '0 : apb.P_rdata;
            err_q    <= apb.P_slverr;
          end else if (wait_q == WAIT_LAST) begin
            // Slave never answered: abort with an error and no data.
            state_q  <= IDLE;
            selx_q   <= 1'b0;
            enable_q <= 1'b0;
            done0_q  <= ~owner_q;
            done1_q  <= owner_q;
            rdata_q  <= '0;
            err_q    <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          selx_q   <= 1'b0;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign rq0_gnt      = gnt0_q;
  assign rq1_gnt      = gnt1_q;
  assign rq0_done     = done0_q;
  assign rq1_done     = done1_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign apb.P_addr   = addr_q;
  assign apb.P_selx   = selx_q;
  assign apb.P_enable = enable_q;
  assign apb.P_write  = write_q;
  assign apb.P_wdata  = wdata_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Randomized self-checking bench for apb_arb_master with a transfer-level model.
// Model tracks last grant owner and expected response; slave is emulated per transfer.
// Each transfer is checked at grant, every ACCESS cycle, and at done.
module tb_apb_arb_master;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          P_clk = 1'b0;
  logic          P_rst;
  logic          rq0_req, rq0_write, rq0_gnt, rq0_done;
  logic [AW-1:0] rq0_addr;
  logic [DW-1:0] rq0_wdata;
  logic          rq1_req, rq1_write, rq1_gnt, rq1_done;
  logic [AW-1:0] rq1_addr;
  logic [DW-1:0] rq1_wdata;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  apb_arb_master_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

  apb_arb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .P_clk     (P_clk),
    .P_rst     (P_rst),
    .rq0_req   (rq0_req),
    .rq0_write (rq0_write),
    .rq0_addr  (rq0_addr),
    .rq0_wdata (rq0_wdata),
    .rq0_gnt   (rq0_gnt),
    .rq0_done  (rq0_done),
    .rq1_req   (rq1_req),
    .rq1_write (rq1_write),
    .rq1_addr  (rq1_addr),
    .rq1_wdata (rq1_wdata),
    .rq1_gnt   (rq1_gnt),
    .rq1_done  (rq1_done),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (apb)
  );

  always #5 P_clk = ~P_clk;

  int            n_checks = 0;
  int            n_errors = 0;
  int            last_gnt = 1;     // after reset requester 0 has priority
  logic [DW-1:0] exp_rdata = '0;
  logic          exp_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rand_cmds();
    rq0_write = 1'($urandom);
    rq0_addr  = $urandom;
    rq0_wdata = $urandom;
    rq1_write = 1'($urandom);
    rq1_addr  = $urandom;
    rq1_wdata = $urandom;
  endtask

  // Entered #1 after an edge with the DUT in IDLE; returns #1 after the done edge.
  task automatic run_xfer(input bit r0, input bit r1, input int w, input bit serr,
                          input bit hold, input logic [DW-1:0] rd);
    int            win;
    int            n;
    int            exp_n;
    bit            wr;
    bit            done_seen;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    rq0_req = r0;
    rq1_req = r1;
    win = (r0 && r1) ? ((last_gnt == 0) ? 1 : 0) : (r1 ? 1 : 0);
    wr  = (win == 1) ? rq1_write : rq0_write;
    a   = (win == 1) ? rq1_addr  : rq0_addr;
    wd  = (win == 1) ? rq1_wdata : rq0_wdata;
    @(posedge P_clk); #1;
    chk("gnt0", rq0_gnt, win == 0);
    chk("gnt1", rq1_gnt, win == 1);
    chk("setup_sel", apb.P_selx, 1);
    chk("setup_en", apb.P_enable, 0);
    chk("setup_addr", apb.P_addr, a);
    chk("setup_write", apb.P_write, wr);
    chk("setup_wdata", apb.P_wdata, wd);
    chk("rsp_hold_data", rsp_rdata, exp_rdata);
    chk("rsp_hold_err", rsp_err, exp_err);
    last_gnt = win;
    if (!hold) begin
      rq0_req = 1'b0;
      rq1_req = 1'b0;
    end
    apb.P_ready  = 1'b0;
    apb.P_slverr = 1'b0;
    apb.P_rdata  = ~rd;
    n = 0;
    done_seen = 0;
    for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
      @(posedge P_clk); #1;
      if (rq0_done || rq1_done) begin
        done_seen = 1;
      end else begin
        chk("acc_en", apb.P_enable, 1);
        chk("acc_sel", apb.P_selx, 1);
        chk("acc_addr", apb.P_addr, a);
        chk("acc_write", apb.P_write, wr);
        chk("acc_wdata", apb.P_wdata, wd);
        chk("acc_gnt", {rq0_gnt, rq1_gnt}, 0);
        if (n >= w) begin
          apb.P_ready  = 1'b1;
          apb.P_slverr = serr;
          apb.P_rdata  = rd;
        end else begin
          apb.P_ready  = 1'b0;
          apb.P_slverr = 1'($urandom);
          apb.P_rdata  = $urandom;
        end
        n++;
        // Requests while busy must be ignored.
        if (!hold) begin
          rq0_req = 1'($urandom);
          rq1_req = 1'($urandom);
        end
      end
    end
    chk("done_seen", done_seen, 1);
    exp_n = (w < TMO) ? w + 1 : TMO;
    chk("acc_cycles", n, exp_n);
    chk("done0", rq0_done, win == 0);
    chk("done1", rq1_done, win == 1);
    chk("done_sel", apb.P_selx, 0);
    chk("done_en", apb.P_enable, 0);
    if (w < TMO) begin
      exp_err   = serr;
      exp_rdata = wr ? '0 : rd;
    end else begin
      exp_err   = 1'b1;
      exp_rdata = '0;
    end
    chk("rsp_data", rsp_rdata, exp_rdata);
    chk("rsp_err", rsp_err, exp_err);
    apb.P_ready  = 1'b0;
    apb.P_slverr = 1'b0;
    if (hold) begin
      rq0_req = r0;
      rq1_req = r1;
    end else begin
      rq0_req = 1'b0;
      rq1_req = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    P_rst = 1'b0;
    rq0_req = 1'b0; rq1_req = 1'b0;
    rq0_write = 1'b0; rq1_write = 1'b0;
    rq0_addr = '0; rq1_addr = '0;
    rq0_wdata = '0; rq1_wdata = '0;
    apb.P_ready = 1'b0; apb.P_slverr = 1'b0; apb.P_rdata = '0;
    repeat (3) @(posedge P_clk);
    #1;
    chk("rst_sel", apb.P_selx, 0);
    chk("rst_en", apb.P_enable, 0);
    chk("rst_write", apb.P_write, 0);
    chk("rst_addr", apb.P_addr, 0);
    chk("rst_wdata", apb.P_wdata, 0);
    chk("rst_gnt", {rq0_gnt, rq1_gnt}, 0);
    chk("rst_done", {rq0_done, rq1_done}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    P_rst = 1'b1;

    // Single zero-wait write from requester 0.
    rq0_write = 1'b1; rq0_addr = 32'h4; rq0_wdata = 32'h7;
    run_xfer(1, 0, 0, 0, 0, 32'h1234);

    // Read from requester 1 with two wait states.
    rq1_write = 1'b0; rq1_addr = 32'h4; rq1_wdata = 32'h0;
    run_xfer(0, 1, 2, 0, 0, 32'h7);

    // Slave never ready: abort after TMO ACCESS cycles.
    rq0_write = 1'b0; rq0_addr = 32'h40;
    run_xfer(1, 0, 10, 0, 0, 32'hDEAD);

    // Slave error on a zero-wait read.
    rq1_write = 1'b0; rq1_addr = 32'h80;
    run_xfer(0, 1, 0, 1, 0, 32'h55);

    // Continuous contention: grants must alternate.
    for (int i = 0; i < 4; i++) begin
      rand_cmds();
      run_xfer(1, 1, 0, 0, (i < 3), $urandom);
    end

    // Random mix of patterns, wait states, errors and back-to-back holds.
    for (int i = 0; i < 40; i++) begin
      int pat;
      pat = $urandom_range(1, 3);
      rand_cmds();
      run_xfer(pat[0], pat[1], $urandom_range(0, 6), 1'($urandom),
               (i < 39) ? 1'($urandom) : 1'b0, $urandom);
    end

    // Reset in the middle of ACCESS after requester 0 was just granted.
    rand_cmds();
    rq0_req = 1'b1;
    @(posedge P_clk); #1;
    chk("mr_gnt0", rq0_gnt, 1);
    rq0_req = 1'b0;
    @(posedge P_clk); #1;
    chk("mr_access", apb.P_enable, 1);
    apb.P_ready = 1'b0;
    P_rst = 1'b0;
    @(posedge P_clk); #1;
    chk("mr_sel", apb.P_selx, 0);
    chk("mr_en", apb.P_enable, 0);
    chk("mr_done", {rq0_done, rq1_done}, 0);
    chk("mr_addr", apb.P_addr, 0);
    chk("mr_rdata", rsp_rdata, 0);
    chk("mr_err", rsp_err, 0);
    P_rst = 1'b1;
    last_gnt  = 1;
    exp_rdata = '0;
    exp_err   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge P_clk); #1;
      chk("mr_no_done", {rq0_done, rq1_done}, 0);
    end
    rand_cmds();
    run_xfer(1, 1, 1, 0, 0, $urandom);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum ACCESS-phase wait cycles before abort (range 1..255).
REQ-004 SHALL have port P_clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port P_rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports rqN_req  input  1  transfer request, N=0,1.
REQ-007 SHALL have ports rqN_write  input  1  1=write, 0=read.
REQ-008 SHALL have ports rqN_addr  input  ADDR_W  transfer address.
REQ-009 SHALL have ports rqN_wdata  input  DATA_W  write data.
REQ-010 SHALL have ports rqN_gnt  output  1  one-cycle pulse: command accepted.
REQ-011 SHALL have ports rqN_done  output  1  one-cycle pulse: transfer complete.
REQ-012 SHALL have port rsp_rdata  output  DATA_W  read data, valid with done.
REQ-013 SHALL have port rsp_err  output  1  error status, valid with done.
REQ-014 SHALL have ports P_addr/P_selx/P_enable/P_write/P_wdata  output  ADDR_W/1/1/1/DATA_W  APB master request.
REQ-015 SHALL have ports P_ready/P_slverr/P_rdata  input  1/1/DATA_W  APB slave response.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, ACCESS; all outputs registered.
REQ-017 In IDLE, requests SHALL be sampled; with none asserted, FSM stays IDLE.
REQ-018 On a sampled request, next edge SHALL enter SETUP: P_selx=1, P_enable=0, rqN_gnt=1 for owner, command latched into P_addr/P_write/P_wdata.
REQ-019 SETUP SHALL always last exactly one cycle, then enter ACCESS with P_enable=1, P_selx=1.
REQ-020 P_addr, P_write, P_wdata SHALL stay constant from SETUP through final ACCESS cycle.
REQ-021 In ACCESS with P_ready=1, next edge SHALL enter IDLE: P_selx=P_enable=0, rqN_done=1 for owner, rsp_rdata=P_rdata (reads) or 0 (writes), rsp_err=P_slverr.
REQ-022 Arbitration SHALL be round-robin: single request wins; both requesting, the requester not granted last wins; after reset requester 0 has priority.
REQ-023 Requests SHALL be ignored outside IDLE; a request held after done SHALL start a new transfer (minimum 3 cycles per transfer, zero-wait slave).
REQ-024 A wait counter SHALL count ACCESS cycles with P_ready=0; when it reaches TIMEOUT, next edge SHALL end the transfer as in REQ-021 but with rsp_err=1, rsp_rdata=0.
REQ-025 The wait counter SHALL clear on entry to SETUP.
REQ-026 gnt and done SHALL never be asserted for both requesters in the same cycle.
REQ-027 rsp_rdata/rsp_err SHALL hold their values until the next done.

Reset
REQ-028 While P_rst=0 at an edge, next state SHALL be IDLE; P_selx, P_enable, P_write, gnt, done, rsp_err = 0; P_addr, P_wdata, rsp_rdata = 0; wait counter 0; priority to requester 0.
REQ-029 Reset during SETUP or ACCESS SHALL abort the transfer with no done pulse.

Verification
REQ-030 Single write: rq0 write addr=0x4 wdata=0x7, P_ready tied 1 -> gnt0 at cycle+1, P_enable at +2, done0 at +3, rsp_err=0.
REQ-031 Read with 2 wait states: rq1 read addr=0x4, P_ready low 2 ACCESS cycles, P_rdata=0x7 -> done1 after 3 ACCESS cycles, rsp_rdata=0x7, addr stable throughout.
REQ-032 Contention: rq0 and rq1 held high continuously -> grants alternate 0,1,0,1; each done matches its gnt owner.
REQ-033 Timeout: TIMEOUT=4, P_ready stuck 0 -> exactly 4 ACCESS cycles, then done with rsp_err=1, rsp_rdata=0.
REQ-034 Slave error: P_slverr=1 with P_ready=1 -> done with rsp_err=1.
REQ-035 Mid-transfer reset: P_rst=0 during ACCESS -> P_selx/P_enable 0 next edge, no done; after release, rq0 wins a simultaneous request.
